// File: rtl/bist_session_ctrl.sv
// Logic-BIST session sequencer for the c432 loop: seed TPG/MISR, run patterns, drain, compare signature.
// Latency: done rises after edge k+NUM_PATTERNS+PIPE_DEPTH+2 when start is sampled at edge k.
// Backpressure: none; start is accepted only in IDLE/DONE, abort cancels any busy state next edge.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   start, abort      session request / cancel
//   misr_sig          live MISR signature; golden_sig expected signature (stable while busy)
//   bist              mode-mux select (1 = TPG patterns drive the CUT)
//   tpg_rst, tpg_en   TPG reseed / advance
//   misr_clr, misr_en MISR synchronous clear / compaction enable
//   pattern_cnt       patterns applied this session (saturates at NUM_PATTERNS)
//   busy, done, pass  session status; pass valid while done
//   sig_captured      signature sampled on the COMPARE exit edge
//   aborted           one-cycle pulse after an accepted abort
module bist_session_ctrl #(
  parameter int NUM_PATTERNS = 23,
  parameter int PIPE_DEPTH   = 4,
  parameter int SIG_W        = 4,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] misr_sig,
  input  logic [SIG_W-1:0] golden_sig,
  output logic             bist,
  output logic             tpg_rst,
  output logic             tpg_en,
  output logic             misr_clr,
  output logic             misr_en,
  output logic [CNT_W-1:0] pattern_cnt,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig_captured,
  output logic             aborted
);

  // A zero-depth pipe still needs a legal (1-bit) counter; it is simply never used.
  localparam int DRN_W = (PIPE_DEPTH > 0) ? $clog2(PIPE_DEPTH + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_PATTERNS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PATTERNS - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_DRAIN,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DRN_W-1:0] drain_cnt;
  logic             accept_start;
  logic             accept_abort;

  // start is only looked at when no session is in flight.
  assign accept_start = start && ((state == S_IDLE) || (state == S_DONE));
  assign accept_abort = abort && busy;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_SEED;
      S_SEED:    state_nxt = S_RUN;
      // The edge that moves the count from NUM_PATTERNS-1 to NUM_PATTERNS ends RUN.
      S_RUN:     if (pattern_cnt == CNT_LAST)
                   state_nxt = (PIPE_DEPTH == 0) ? S_COMPARE : S_DRAIN;
      S_DRAIN:   if (drain_cnt == DRN_LAST) state_nxt = S_COMPARE;
      S_COMPARE: state_nxt = S_DONE;
      S_DONE:    if (start) state_nxt = S_SEED;
      default:   state_nxt = S_IDLE;
    endcase
    // Abort overrides every other transition, but only while a session is active.
    if (accept_abort) state_nxt = S_IDLE;
  end

  // Control outputs are pure decodes of the registered state.
  always_comb begin
    bist     = 1'b0;
    tpg_rst  = 1'b0;
    tpg_en   = 1'b0;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_SEED: begin
        bist     = 1'b1;
        tpg_rst  = 1'b1;
        misr_clr = 1'b1;
        busy     = 1'b1;
      end
      S_RUN: begin
        bist    = 1'b1;
        tpg_en  = 1'b1;
        misr_en = 1'b1;
        busy    = 1'b1;
      end
      S_DRAIN: begin
        bist    = 1'b1;
        misr_en = 1'b1;
        busy    = 1'b1;
      end
      S_COMPARE: begin
        bist = 1'b1;
        busy = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      pattern_cnt  <= '0;
      drain_cnt    <= '0;
      pass         <= 1'b0;
      sig_captured <= '0;
      aborted      <= 1'b0;
    end else begin
      state   <= state_nxt;
      aborted <= accept_abort;

      // The count also advances on an abort edge: that RUN cycle's pattern was applied.
      if (accept_start) begin
        pattern_cnt <= '0;
      end else if ((state == S_RUN) && (pattern_cnt != CNT_MAX)) begin
        pattern_cnt <= pattern_cnt + CNT_W'(1);
      end

      if (state == S_RUN) begin
        drain_cnt <= '0;
      end else if (state == S_DRAIN) begin
        drain_cnt <= drain_cnt + DRN_W'(1);
      end

      if (accept_start || accept_abort) begin
        pass <= 1'b0;
      end else if (state == S_COMPARE) begin
        sig_captured <= misr_sig;
        pass         <= (misr_sig == golden_sig);
      end
    end
  end

endmodule
